// File: rtl/dpram_init.sv
// Simple dual-port synchronous RAM with byte-lane writes, selectable read-during-write
// policy, optional output register, and a post-reset sweep to a known value.
module dpram_init #(
  parameter int unsigned   WD       = 16,
  parameter int unsigned   AD       = 4,
  parameter int unsigned   RDW_MODE = 0,
  parameter int unsigned   OREG     = 0,
  parameter logic [WD-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            init_busy,
  input  logic            wr_cs_n,
  input  logic [AD-1:0]   wr_addr,
  input  logic [WD-1:0]   wr_din,
  input  logic [WD/8-1:0] wr_be,
  input  logic            rd_cs_n,
  input  logic [AD-1:0]   rd_addr,
  output logic [WD-1:0]   rd_dout,
  output logic            rd_valid
);

  localparam int unsigned DP = 1 << AD;
  localparam int unsigned NB = WD / 8;

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AD-1:0]   cnt_q, cnt_d;
  logic            init_wr_c;
  logic            wr_en_c;
  logic            rd_en_c;
  logic [WD-1:0]   rd_word_c;
  logic [WD-1:0]   mem [DP];

  // State and sweep counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep every address once, then open the ports
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_wr_c = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr_c = 1'b1;
        cnt_d     = cnt_q + AD'(1);
        if (cnt_q == AD'(DP - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_busy <= 1'b1;
    end else begin
      init_busy <= (state_d == ST_INIT);
    end
  end

  assign wr_en_c = (state_q == ST_READY) && !wr_cs_n;
  assign rd_en_c = (state_q == ST_READY) && !rd_cs_n;

  // Storage array; contents are left alone on the reset edge itself
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_wr_c) begin
        mem[cnt_q] <= INIT_VAL;
      end else if (wr_en_c) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) begin
            mem[wr_addr][8*i +: 8] <= wr_din[8*i +: 8];
          end
        end
      end
    end
  end

  // Read word with optional write-first merge on a same-address collision
  always_comb begin
    rd_word_c = mem[rd_addr];
    if ((RDW_MODE != 0) && wr_en_c && (rd_addr == wr_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_word_c[8*i +: 8] = wr_din[8*i +: 8];
        end
      end
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [WD-1:0] stg_data;
      logic          stg_valid;

      // Two-stage read pipeline; rd_dout only moves when a result lands
      always_ff @(posedge clk) begin
        if (rst) begin
          stg_data  <= '0;
          stg_valid <= 1'b0;
          rd_dout   <= '0;
          rd_valid  <= 1'b0;
        end else begin
          stg_valid <= rd_en_c;
          if (rd_en_c) begin
            stg_data <= rd_word_c;
          end
          rd_valid <= stg_valid;
          if (stg_valid) begin
            rd_dout <= stg_data;
          end
        end
      end
    end else begin : g_direct
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_dout  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_en_c;
          if (rd_en_c) begin
            rd_dout <= rd_word_c;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dpram_init.sv
// Directed bench for dpram_init: one old-data/latency-1 instance and one
// write-first/latency-2 instance share the same stimulus.
module tb_dpram_init;

  logic        clk;
  logic        rst;
  logic        wr_cs_n;
  logic [3:0]  wr_addr;
  logic [15:0] wr_din;
  logic [1:0]  wr_be;
  logic        rd_cs_n;
  logic [3:0]  rd_addr;
  logic        busy0, busy1;
  logic [15:0] dout0, dout1;
  logic        val0, val1;

  int checks = 0;
  int errors = 0;

  dpram_init #(.WD(16), .AD(4), .RDW_MODE(0), .OREG(0), .INIT_VAL(16'hA5A5)) dut0 (
    .clk(clk), .rst(rst), .init_busy(busy0),
    .wr_cs_n(wr_cs_n), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .rd_cs_n(rd_cs_n), .rd_addr(rd_addr), .rd_dout(dout0), .rd_valid(val0)
  );

  dpram_init #(.WD(16), .AD(4), .RDW_MODE(1), .OREG(1), .INIT_VAL(16'hA5A5)) dut1 (
    .clk(clk), .rst(rst), .init_busy(busy1),
    .wr_cs_n(wr_cs_n), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .rd_cs_n(rd_cs_n), .rd_addr(rd_addr), .rd_dout(dout1), .rd_valid(val1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        wcs_n;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        rcs_n;
    logic [3:0]  ra;
    logic        v0;
    logic [15:0] d0;
    logic        v1;
    logic [15:0] d1;
  } vec_t;

  vec_t vecs[22];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Release reset and count sweep cycles; optionally hammer the ports meanwhile
  task automatic sweep(input string nm, input bit hammer);
    int n = 0;
    int vals = 0;
    rst = 1'b0;
    while (busy0 && n < 100) begin
      if (hammer) begin
        wr_cs_n = 1'b0; rd_cs_n = 1'b0;
        wr_addr = 4'(15 - n); rd_addr = 4'(n);
        wr_din  = 16'hFFFF; wr_be = 2'b11;
      end
      tick();
      n++;
      if (val0 || val1) vals++;
    end
    wr_cs_n = 1'b1; rd_cs_n = 1'b1;
    chk({nm, "_busy_cycles"}, 32'(n), 32'd16);
    chk({nm, "_busy1_done"}, 32'(busy1), 32'd0);
    chk({nm, "_no_valid"}, 32'(vals), 32'd0);
  endtask

  initial begin
    // wcs_n wa wd be rcs_n ra | v0 d0 | v1 d1
    vecs[0]  = '{1'b0, 4'd3, 16'h1234, 2'b11, 1'b1, 4'd0, 1'b0, 16'hA5A5, 1'b0, 16'hA5A5};
    vecs[1]  = '{1'b0, 4'd3, 16'hFFFF, 2'b01, 1'b1, 4'd0, 1'b0, 16'hA5A5, 1'b0, 16'hA5A5};
    vecs[2]  = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd3, 1'b1, 16'h12FF, 1'b0, 16'hA5A5};
    vecs[3]  = '{1'b0, 4'd5, 16'h0000, 2'b11, 1'b1, 4'd0, 1'b0, 16'h12FF, 1'b1, 16'h12FF};
    vecs[4]  = '{1'b0, 4'd5, 16'hBEEF, 2'b10, 1'b0, 4'd5, 1'b1, 16'h0000, 1'b0, 16'h12FF};
    vecs[5]  = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd5, 1'b1, 16'hBE00, 1'b1, 16'hBE00};
    vecs[6]  = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b0, 16'hBE00, 1'b1, 16'hBE00};
    vecs[7]  = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b0, 16'hBE00, 1'b0, 16'hBE00};
    vecs[8]  = '{1'b0, 4'd0, 16'h0010, 2'b11, 1'b1, 4'd0, 1'b0, 16'hBE00, 1'b0, 16'hBE00};
    vecs[9]  = '{1'b0, 4'd1, 16'h0011, 2'b11, 1'b1, 4'd0, 1'b0, 16'hBE00, 1'b0, 16'hBE00};
    vecs[10] = '{1'b0, 4'd2, 16'h0012, 2'b11, 1'b1, 4'd0, 1'b0, 16'hBE00, 1'b0, 16'hBE00};
    vecs[11] = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1, 16'h0010, 1'b0, 16'hBE00};
    vecs[12] = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd1, 1'b1, 16'h0011, 1'b1, 16'h0010};
    vecs[13] = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd2, 1'b1, 16'h0012, 1'b1, 16'h0011};
    vecs[14] = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b0, 16'h0012, 1'b1, 16'h0012};
    vecs[15] = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b0, 16'h0012, 1'b0, 16'h0012};
    vecs[16] = '{1'b0, 4'd8, 16'h7777, 2'b11, 1'b0, 4'd9, 1'b1, 16'hA5A5, 1'b0, 16'h0012};
    vecs[17] = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd8, 1'b1, 16'h7777, 1'b1, 16'hA5A5};
    vecs[18] = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b0, 16'h7777, 1'b1, 16'h7777};
    vecs[19] = '{1'b0, 4'd8, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b0, 16'h7777, 1'b0, 16'h7777};
    vecs[20] = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd8, 1'b1, 16'h7777, 1'b0, 16'h7777};
    vecs[21] = '{1'b1, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b0, 16'h7777, 1'b1, 16'h7777};

    rst = 1'b1; wr_cs_n = 1'b1; rd_cs_n = 1'b1;
    wr_addr = '0; wr_din = '0; wr_be = '0; rd_addr = '0;
    tick();
    tick();
    chk("rst_busy0", 32'(busy0), 32'd1);
    chk("rst_busy1", 32'(busy1), 32'd1);
    chk("rst_val0", 32'(val0), 32'd0);
    chk("rst_val1", 32'(val1), 32'd0);
    chk("rst_dout0", 32'(dout0), 32'h0);
    chk("rst_dout1", 32'(dout1), 32'h0);

    // Sweep with both ports held active; none of it may take effect
    sweep("init", 1'b1);

    // Every word reads back as the init value, one strobe per read
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        rd_cs_n = 1'b0; rd_addr = 4'(k);
      end else begin
        rd_cs_n = 1'b1;
      end
      tick();
      chk($sformatf("rdall%0d_val0", k), 32'(val0), 32'(k < 16));
      if (k < 16) chk($sformatf("rdall%0d_dout0", k), 32'(dout0), 32'hA5A5);
      chk($sformatf("rdall%0d_val1", k), 32'(val1), 32'(k >= 1 && k <= 16));
      if (k >= 1 && k <= 16) chk($sformatf("rdall%0d_dout1", k), 32'(dout1), 32'hA5A5);
    end

    for (int i = 0; i < 22; i++) begin
      wr_cs_n = vecs[i].wcs_n; wr_addr = vecs[i].wa; wr_din = vecs[i].wd; wr_be = vecs[i].be;
      rd_cs_n = vecs[i].rcs_n; rd_addr = vecs[i].ra;
      tick();
      chk($sformatf("v%0d_val0", i), 32'(val0), 32'(vecs[i].v0));
      chk($sformatf("v%0d_dout0", i), 32'(dout0), 32'(vecs[i].d0));
      chk($sformatf("v%0d_val1", i), 32'(val1), 32'(vecs[i].v1));
      chk($sformatf("v%0d_dout1", i), 32'(dout1), 32'(vecs[i].d1));
    end

    // Reset while a read sits in the output register stage
    wr_cs_n = 1'b1; rd_cs_n = 1'b0; rd_addr = 4'd8;
    tick();
    chk("mid_val0", 32'(val0), 32'd1);
    chk("mid_dout0", 32'(dout0), 32'h7777);
    chk("mid_val1_pending", 32'(val1), 32'd0);
    rd_cs_n = 1'b1; rst = 1'b1;
    tick();
    chk("mid_rst_val1", 32'(val1), 32'd0);
    chk("mid_rst_dout1", 32'(dout1), 32'h0);
    chk("mid_rst_dout0", 32'(dout0), 32'h0);
    chk("mid_rst_busy1", 32'(busy1), 32'd1);
    sweep("mid", 1'b0);

    rd_cs_n = 1'b0; rd_addr = 4'd8;
    tick();
    rd_cs_n = 1'b1;
    chk("post_val0", 32'(val0), 32'd1);
    chk("post_dout0", 32'(dout0), 32'hA5A5);
    tick();
    chk("post_val1", 32'(val1), 32'd1);
    chk("post_dout1", 32'(dout1), 32'hA5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_init.md
# dpram_init

Parametrised simple dual-port synchronous RAM: one write port and one read port, both on one clock, with byte-lane write enables and a selectable read-during-write policy. An optional output register stage adds a pipeline cycle. After every reset, a built-in state machine sweeps the whole array to a known value before the ports are accepted. It replaces the single-port RAM in datapaths that need a concurrent read and write, or deterministic contents after reset.

## Interface
- WD, 16: data width in bits; must be a multiple of 8.
- AD, 4: address width; depth DP = 1 << AD.
- RDW_MODE, 0: same-address read-during-write policy; 0 = old data, 1 = new data (write-first, per byte lane).
- OREG, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- INIT_VAL, 0: WD-bit value written to every word during initialisation.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the initialisation sweep runs; ports are ignored while it is high.
- wr_cs_n  in  1  write select, active low.
- wr_addr  in  AD  write address.
- wr_din  in  WD  write data.
- wr_be  in  WD/8  byte-lane enables; bit i covers wr_din[8i+7:8i].
- rd_cs_n  in  1  read select, active low.
- rd_addr  in  AD  read address.
- rd_dout  out  WD  read data; holds its last value between reads.
- rd_valid  out  1  single-cycle strobe marking fresh rd_dout.

## Operation
- **States:** INIT and READY. The state is held in a register, and init_busy = (state == INIT).
- **Reset edge** (any edge with rst = 1):
  - state <= INIT, cnt <= 0.
  - init_busy = 1, rd_valid = 0, rd_dout = 0.
  - The OREG stage data and valid are cleared.
- **INIT** (each edge with rst = 0):
  - mem[cnt] <= INIT_VAL and cnt <= cnt + 1.
  - When cnt == DP-1, state <= READY.
  - wr_cs_n and rd_cs_n are ignored, and rd_valid stays 0.
- **READY, write:** at an edge with wr_cs_n = 0, for each i with wr_be[i] = 1, lane i of mem[wr_addr] <= lane i of wr_din. Lanes with wr_be[i] = 0 are unchanged. wr_be = 0 means no write.
- **READY, read:** at an edge with rd_cs_n = 0, the addressed word is returned with the configured latency.
- **Same-address read-during-write** (both selects low, rd_addr == wr_addr):
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: returns wr_din in enabled lanes and the old word in the others.
  - Different addresses never interact.
- **Arithmetic:** cnt is AD+1 bits wide or compared before it wraps. The sweep covers exactly addresses 0..DP-1 once each.
- **Reset mid-operation** (rst during INIT or READY):
  - The sweep restarts from address 0.
  - In-flight reads, including one held in the OREG stage, are dropped and produce no rd_valid.
  - Memory contents already written are not otherwise guaranteed until the sweep completes.

## Timing
- **Reset to ready:** rst is sampled high at edge E0 and low from E1 onward. The sweep writes addresses 0..DP-1 at E1..E_DP, and init_busy reads 0 after E_DP. A request is serviced only if init_busy was 0 before the sampling edge.
- **OREG = 0:** a read sampled at edge En updates rd_dout and asserts rd_valid after En. rd_valid deasserts after En+1 unless another read was sampled there.
- **OREG = 1:** the same read appears after En+1. Back-to-back reads give back-to-back rd_valid, one result per cycle, in order.
- **Writes:** visible to a read of the same address sampled at the next edge regardless of mode. RDW_MODE affects only the same edge.
- **rd_dout** is not altered when no read completes.

## Test plan
- **Reset sweep:** WD=16, AD=4, INIT_VAL=16'hA5A5. Pulse rst for 1 cycle → init_busy high for exactly 16 cycles. Then read all 16 addresses → every word is 16'hA5A5, one rd_valid per read.
- **Byte lanes:** write 16'h1234 to address 3 with wr_be = 2'b11, then 16'hFFFF with wr_be = 2'b01. Read address 3 → 16'h12FF.
- **Read-during-write:** address 5 holds 16'h0000. Write 16'hBEEF with wr_be = 2'b10 and read address 5 on the same edge → RDW_MODE=0 returns 16'h0000; RDW_MODE=1 returns 16'hBE00. A read on the next edge returns 16'hBE00 in both modes.
- **Latency:** OREG=1, reads of addresses 0, 1, 2 on consecutive edges after writing 16'h0010, 16'h0011, 16'h0012 → rd_valid high for 3 consecutive cycles starting 2 edges after the first request, with data in order.
- **Ignore during INIT:** assert wr_cs_n = 0 and rd_cs_n = 0 throughout the sweep → rd_valid stays 0, and all words read INIT_VAL afterwards.
- **Mid-flight reset:** OREG=1, issue a read, then assert rst on the next edge → no rd_valid, rd_dout = 0, and init_busy high for a full 16 cycles.
